// File: rtl/toggle_scanner.sv
// Scanner for NUM three-position toggles. Each toggle is synchronized, decoded,
// debounced on a slow tick, and position changes are queued as round-robin events.
module toggle_scanner #(
    parameter int NUM    = 4,
    parameter int IDXW   = 2,
    parameter int DIV    = 12000,
    parameter int DB_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*NUM-1:0]  pkgpin,
    output logic [2*NUM-1:0]  pos,
    output logic              evt_valid,
    output logic [IDXW-1:0]   evt_idx,
    output logic [1:0]        evt_pos,
    input  logic              evt_ack,
    output logic              overrun
);

    // state   | meaning
    // IDLE    | no event presented; grants the next pending toggle
    // PRESENT | event held on evt_* until the consumer acks it
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state, state_nxt;
    logic [2*NUM-1:0]  sync_a, sync_b;
    logic [15:0]       pre_cnt;
    logic              tick;
    logic [NUM-1:0]    commit;
    logic [NUM-1:0]    pending;
    logic [NUM-1:0]    grant_clr;
    logic [IDXW-1:0]   last, last_nxt;
    logic              valid_nxt;
    logic [IDXW-1:0]   idx_nxt;
    logic [1:0]        epos_nxt;

    // Returns {valid, position}; a pair of 00 means both contacts closed.
    function automatic logic [2:0] decode(input logic [1:0] pins);
        case (pins)
            2'b01:   decode = 3'b100;
            2'b11:   decode = 3'b101;
            2'b10:   decode = 3'b110;
            default: decode = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= pkgpin;
            sync_b <= sync_a;
        end
    end

    assign tick = (pre_cnt == 16'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_tog
        logic [2:0] dec;
        logic [1:0] cand;
        logic [1:0] pos_r;
        logic [3:0] cnt;
        logic [3:0] cnt_inc;

        assign dec     = decode(sync_b[2*gi +: 2]);
        assign cnt_inc = cnt + 4'd1;
        assign commit[gi] = tick && dec[2] && (dec[1:0] != pos_r) &&
                            (dec[1:0] == cand) && (cnt_inc == 4'(DB_CNT));
        assign pos[2*gi +: 2] = pos_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand  <= 2'b01;
                pos_r <= 2'b01;
                cnt   <= '0;
            end else if (tick && dec[2]) begin
                if (dec[1:0] == pos_r) begin
                    cnt <= '0;
                end else if (dec[1:0] != cand) begin
                    cand <= dec[1:0];
                    cnt  <= 4'd1;
                end else if (commit[gi]) begin
                    pos_r <= dec[1:0];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // A commit landing on the grant cycle re-arms pending instead of overrunning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~grant_clr) | commit;
            overrun <= |(commit & pending & ~grant_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_pos   <= 2'b01;
            last      <= IDXW'(NUM - 1);
        end else begin
            state     <= state_nxt;
            evt_valid <= valid_nxt;
            evt_idx   <= idx_nxt;
            evt_pos   <= epos_nxt;
            last      <= last_nxt;
        end
    end

    always_comb begin
        int  j;
        int  sel;
        logic found;
        state_nxt = state;
        valid_nxt = evt_valid;
        idx_nxt   = evt_idx;
        epos_nxt  = evt_pos;
        last_nxt  = last;
        grant_clr = '0;
        j         = 0;
        sel       = 0;
        found     = 1'b0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NUM; k++) begin
                    j = int'(last) + k;
                    if (j >= NUM) j = j - NUM;
                    if (!found && pending[j]) begin
                        found = 1'b1;
                        sel   = j;
                    end
                end
                if (found) begin
                    grant_clr[sel] = 1'b1;
                    idx_nxt        = IDXW'(sel);
                    epos_nxt       = pos[2*sel +: 2];
                    valid_nxt      = 1'b1;
                    state_nxt      = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ack) begin
                    valid_nxt = 1'b0;
                    last_nxt  = evt_idx;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_toggle_scanner.sv
// Directed bench for toggle_scanner with NUM=4, DIV=4, DB_CNT=3.
module tb_toggle_scanner;
    localparam int NUM    = 4;
    localparam int IDXW   = 2;
    localparam int DIV    = 4;
    localparam int DB_CNT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      pkgpin = 8'hFF;
    logic [7:0]      pos;
    logic            evt_valid;
    logic [IDXW-1:0] evt_idx;
    logic [1:0]      evt_pos;
    logic            evt_ack = 1'b0;
    logic            overrun;

    int errors = 0;
    int checks = 0;
    int cyc;
    int valid_seen = 0;
    int ovr_seen = 0;

    toggle_scanner #(.NUM(NUM), .IDXW(IDXW), .DIV(DIV), .DB_CNT(DB_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .pkgpin(pkgpin), .pos(pos),
        .evt_valid(evt_valid), .evt_idx(evt_idx), .evt_pos(evt_pos),
        .evt_ack(evt_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; debounce ticks land where cyc % DIV == 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (evt_valid === 1'b1) valid_seen++;
        if (overrun === 1'b1)   ovr_seen++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic align();
        do step(); while (cyc % DIV != 0);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (n < 200 && evt_valid !== 1'b1) begin
            step();
            n++;
        end
        ok = (evt_valid === 1'b1);
    endtask

    task automatic do_ack();
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (pos !== 8'h55) begin errors++; $display("FAIL reset_pos: got %h expected 55", pos); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++; if (evt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", evt_idx); end
        checks++; if (evt_pos !== 2'b01) begin errors++; $display("FAIL reset_evt_pos: got %b expected 01", evt_pos); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_idle();
        int v0;
        v0 = valid_seen;
        repeat (40) step();
        checks++; if (pos !== 8'h55) begin errors++; $display("FAIL idle_pos: got %h expected 55", pos); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL idle_no_event: got %0d valid cycles expected 0", valid_seen - v0); end
    endtask

    task automatic test_single();
        bit stable;
        align();
        pkgpin = 8'hDF;
        repeat (11) step();
        checks++; if (pos !== 8'h55) begin errors++; $display("FAIL single_pos_early: got %h expected 55", pos); end
        step();
        checks++; if (pos !== 8'h45) begin errors++; $display("FAIL single_pos_commit: got %h expected 45", pos); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b expected 0", evt_valid); end
        step();
        checks++; if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_pos !== 2'b00) begin
            errors++; $display("FAIL single_event: got v=%b idx=%0d pos=%b expected v=1 idx=2 pos=00", evt_valid, evt_idx, evt_pos);
        end
        stable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_pos !== 2'b00) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL single_hold: got unstable event expected held idx=2 pos=00"); end
        do_ack();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got v=%b expected 0", evt_valid); end
    endtask

    task automatic test_chatter();
        int v0;
        v0 = valid_seen;
        for (int t = 0; t < 10; t++) begin
            align();
            pkgpin = (t % 2 == 0) ? 8'hD7 : 8'hDF;
        end
        align();
        pkgpin = 8'hDF;
        repeat (20) step();
        checks++; if (pos !== 8'h45) begin errors++; $display("FAIL chatter_pos: got %h expected 45", pos); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL chatter_no_event: got %0d valid cycles expected 0", valid_seen - v0); end
    endtask

    task automatic test_round_robin();
        bit ok;
        bit held;
        pkgpin = 8'hDE;
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd0 || evt_pos !== 2'b10) begin
            errors++; $display("FAIL rr_setup: got ok=%b idx=%0d pos=%b expected ok=1 idx=0 pos=10", ok, evt_idx, evt_pos);
        end
        do_ack();
        pkgpin = 8'h5F;
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd3 || evt_pos !== 2'b00) begin
            errors++; $display("FAIL rr_first: got ok=%b idx=%0d pos=%b expected ok=1 idx=3 pos=00", ok, evt_idx, evt_pos);
        end
        held = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            if (evt_valid !== 1'b1 || evt_idx !== 2'd3) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL rr_wait_ack: got event change expected idx=3 held"); end
        do_ack();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rr_gap: got v=%b expected 0", evt_valid); end
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd0 || evt_pos !== 2'b01) begin
            errors++; $display("FAIL rr_second: got ok=%b idx=%0d pos=%b expected ok=1 idx=0 pos=01", ok, evt_idx, evt_pos);
        end
        do_ack();
        checks++; if (pos !== 8'h05) begin errors++; $display("FAIL rr_pos: got %h expected 05", pos); end
    endtask

    task automatic test_overrun();
        bit ok;
        int o0;
        int v1;
        pkgpin = 8'h7D;
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd2 || evt_pos !== 2'b01) begin
            errors++; $display("FAIL ovr_blocker: got ok=%b idx=%0d pos=%b expected ok=1 idx=2 pos=01", ok, evt_idx, evt_pos);
        end
        o0 = ovr_seen;
        pkgpin = 8'h7E;
        repeat (40) step();
        checks++; if (pos !== 8'h16) begin errors++; $display("FAIL ovr_pos: got %h expected 16", pos); end
        checks++; if (ovr_seen - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulse cycles expected 1", ovr_seen - o0); end
        checks++; if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_pos !== 2'b01) begin
            errors++; $display("FAIL ovr_presented_stable: got v=%b idx=%0d pos=%b expected v=1 idx=2 pos=01", evt_valid, evt_idx, evt_pos);
        end
        do_ack();
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd0 || evt_pos !== 2'b10) begin
            errors++; $display("FAIL ovr_latest: got ok=%b idx=%0d pos=%b expected ok=1 idx=0 pos=10", ok, evt_idx, evt_pos);
        end
        do_ack();
        v1 = valid_seen;
        repeat (30) step();
        checks++; if (valid_seen != v1) begin errors++; $display("FAIL ovr_single_event: got %0d extra valid cycles expected 0", valid_seen - v1); end
    endtask

    task automatic test_invalid();
        int v0;
        v0 = valid_seen;
        pkgpin = 8'h72;
        repeat (20 * DIV) step();
        checks++; if (pos !== 8'h16) begin errors++; $display("FAIL invalid_pos: got %h expected 16", pos); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL invalid_no_event: got %0d valid cycles expected 0", valid_seen - v0); end
        pkgpin = 8'h7E;
        repeat (20) step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int v0;
        pkgpin = 8'h76;
        wait_valid(ok);
        checks++; if (!ok || evt_idx !== 2'd1 || evt_pos !== 2'b00) begin
            errors++; $display("FAIL rstmid_event: got ok=%b idx=%0d pos=%b expected ok=1 idx=1 pos=00", ok, evt_idx, evt_pos);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_drop: got %b expected 0", evt_valid); end
        checks++; if (pos !== 8'h55) begin errors++; $display("FAIL rstmid_pos: got %h expected 55", pos); end
        pkgpin = 8'hFF;
        repeat (3) step();
        rst_n = 1'b1;
        v0 = valid_seen;
        repeat (40) step();
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL rstmid_no_replay: got %0d valid cycles expected 0", valid_seen - v0); end
        checks++; if (pos !== 8'h55) begin errors++; $display("FAIL rstmid_pos_after: got %h expected 55", pos); end
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        test_idle();
        test_single();
        test_chatter();
        test_round_robin();
        test_overrun();
        test_invalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
